// File: rtl/ball_motion_ctrl.sv
// Per-frame ball physics: tilt -> velocity -> position (10.4 fixed point), with map-based collisions.
// Optional build macro BALL_BOUNCE_EN: wall hits and edge clamps rebound the ball at half speed instead of stopping it.
module ball_motion_ctrl #(
  parameter int unsigned START_X     = 32,
  parameter int unsigned START_Y     = 32,
  parameter int unsigned ACCEL_SHIFT = 2,
  parameter int unsigned VMAX        = 48,
  parameter int unsigned X_MAX       = 639,
  parameter int unsigned Y_MAX       = 479
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              frame_tick,
  input  logic              game_restart,
  input  logic signed [7:0] accel_x,
  input  logic signed [7:0] accel_y,
  output logic              map_req,
  output logic [9:0]        map_x,
  output logic [9:0]        map_y,
  input  logic              map_ack,
  input  logic [1:0]        map_code,
  output logic [9:0]        ball_loc_X,
  output logic [9:0]        ball_loc_Y,
  output logic              hit_a_hole,
  output logic              won_the_game,
  output logic              busy
);

  localparam int unsigned PW = 14;
  localparam int unsigned VW = 8;

  localparam logic [PW-1:0] X_HOME = PW'(START_X * 16);
  localparam logic [PW-1:0] Y_HOME = PW'(START_Y * 16);
  localparam logic [PW-1:0] X_HI   = PW'(X_MAX * 16 + 15);
  localparam logic [PW-1:0] Y_HI   = PW'(Y_MAX * 16 + 15);
  localparam logic [PW-1:0] X_TOP  = PW'(X_MAX * 16);
  localparam logic [PW-1:0] Y_TOP  = PW'(Y_MAX * 16);

  localparam logic signed [VW:0] V_HI = (VW+1)'(VMAX);
  localparam logic signed [VW:0] V_LO = -V_HI;

  localparam logic [1:0] CODE_WALL = 2'b01;
  localparam logic [1:0] CODE_HOLE = 2'b10;
  localparam logic [1:0] CODE_GOAL = 2'b11;

`ifdef BALL_BOUNCE_EN
  localparam bit BOUNCE = 1'b1;
`else
  localparam bit BOUNCE = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, ACCEL, PROBE_X, PROBE_Y, PROBE_F, COMMIT, HOLE, WON} state_t;

  state_t               state;
  logic [PW-1:0]        pos_x, pos_y, cand;
  logic signed [VW-1:0] vx, vy, vx_n, vy_n;
  logic [PW:0]          px, py;
  logic                 clamped, gap, pend_hole, pend_goal;

  // Add the shifted tilt sample to a velocity and saturate to +/-VMAX.
  function automatic logic signed [VW-1:0] integrate(input logic signed [VW-1:0] v,
                                                     input logic signed [VW-1:0] a);
    logic signed [VW-1:0] a_sh;
    logic signed [VW:0]   s;
    a_sh = a >>> ACCEL_SHIFT;
    s = $signed({v[VW-1], v}) + $signed({a_sh[VW-1], a_sh});
    if (s > V_HI)      return VW'(V_HI);
    else if (s < V_LO) return VW'(V_LO);
    else               return s[VW-1:0];
  endfunction

  // Candidate position {clamp_flag, value}, clamped into [0, hi] with overshoot landing on top.
  function automatic logic [PW:0] probe(input logic [PW-1:0] pos, input logic signed [VW-1:0] v,
                                        input logic [PW-1:0] hi, input logic [PW-1:0] top);
    logic signed [PW:0] c;
    c = $signed({1'b0, pos}) + $signed({{(PW+1-VW){v[VW-1]}}, v});
    if (c < 0)                         return {1'b1, {PW{1'b0}}};
    else if (c > $signed({1'b0, hi}))  return {1'b1, top};
    else                               return {1'b0, c[PW-1:0]};
  endfunction

  function automatic logic signed [VW-1:0] rebound(input logic signed [VW-1:0] v);
    logic signed [VW-1:0] h;
    h = v >>> 1;
    return BOUNCE ? -h : '0;
  endfunction

  always_comb begin
    vx_n = integrate(vx, accel_x);
    vy_n = integrate(vy, accel_y);
    px   = probe(pos_x, vx_n, X_HI, X_TOP);
    py   = probe(pos_y, vy, Y_HI, Y_TOP);
  end

  // Each probe drops map_req for one gap cycle after its ack, then the next probe raises it on entry.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || game_restart) begin
      state        <= IDLE;
      pos_x        <= X_HOME;
      pos_y        <= Y_HOME;
      cand         <= '0;
      vx           <= '0;
      vy           <= '0;
      clamped      <= 1'b0;
      gap          <= 1'b0;
      pend_hole    <= 1'b0;
      pend_goal    <= 1'b0;
      map_req      <= 1'b0;
      map_x        <= '0;
      map_y        <= '0;
      ball_loc_X   <= X_HOME[PW-1:4];
      ball_loc_Y   <= Y_HOME[PW-1:4];
      hit_a_hole   <= 1'b0;
      won_the_game <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_tick) begin
            state <= ACCEL;
            busy  <= 1'b1;
          end
        end
        ACCEL: begin
          vx      <= px[PW] ? rebound(vx_n) : vx_n;
          vy      <= vy_n;
          cand    <= px[PW-1:0];
          clamped <= px[PW];
          map_x   <= px[PW-1:4];
          map_y   <= pos_y[PW-1:4];
          map_req <= 1'b1;
          gap     <= 1'b0;
          state   <= PROBE_X;
        end
        PROBE_X: begin
          if (gap) begin
            gap     <= 1'b0;
            vy      <= py[PW] ? rebound(vy) : vy;
            cand    <= py[PW-1:0];
            clamped <= py[PW];
            map_x   <= pos_x[PW-1:4];
            map_y   <= py[PW-1:4];
            map_req <= 1'b1;
            state   <= PROBE_Y;
          end else if (map_req && map_ack) begin
            map_req <= 1'b0;
            gap     <= 1'b1;
            if (map_code == CODE_WALL) begin
              if (!clamped) vx <= rebound(vx);
            end else begin
              pos_x <= cand;
            end
          end
        end
        PROBE_Y: begin
          if (gap) begin
            gap     <= 1'b0;
            map_x   <= pos_x[PW-1:4];
            map_y   <= pos_y[PW-1:4];
            map_req <= 1'b1;
            state   <= PROBE_F;
          end else if (map_req && map_ack) begin
            map_req <= 1'b0;
            gap     <= 1'b1;
            if (map_code == CODE_WALL) begin
              if (!clamped) vy <= rebound(vy);
            end else begin
              pos_y <= cand;
            end
          end
        end
        PROBE_F: begin
          if (map_req && map_ack) begin
            map_req   <= 1'b0;
            pend_hole <= (map_code == CODE_HOLE);
            pend_goal <= (map_code == CODE_GOAL);
            state     <= COMMIT;
          end
        end
        COMMIT: begin
          ball_loc_X <= pos_x[PW-1:4];
          ball_loc_Y <= pos_y[PW-1:4];
          busy       <= 1'b0;
          if (pend_hole) begin
            hit_a_hole <= 1'b1;
            state      <= HOLE;
          end else if (pend_goal) begin
            won_the_game <= 1'b1;
            state        <= WON;
          end else begin
            state <= IDLE;
          end
        end
        HOLE, WON: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ball_motion_ctrl.md
Name: ball_motion_ctrl

Overview:
- Game-physics stage directly upstream of the VGA subsystem.
- Once per video frame, integrates accelerometer tilt into ball velocity and position (10.4 fixed point).
- Resolves wall collisions via a handshaked world-map lookup.
- Drives ball_loc_X/ball_loc_Y, hit_a_hole and won_the_game, which the display path consumes.

Parameters:
- START_X, 32, start/restart pixel column
- START_Y, 32, start/restart pixel row
- ACCEL_SHIFT, 2, arithmetic right shift applied to accel samples before adding to velocity
- VMAX, 48, velocity magnitude limit in 1/16 px per frame
- X_MAX, 639, largest legal column
- Y_MAX, 479, largest legal row

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame; starts an update
- game_restart  in  1  one-cycle pulse; return to start
- accel_x  in  8  signed tilt, X axis
- accel_y  in  8  signed tilt, Y axis
- map_req  out  1  map lookup request
- map_x  out  10  lookup column
- map_y  out  10  lookup row
- map_ack  in  1  lookup complete; map_code valid this cycle
- map_code  in  2  00 open, 01 wall, 10 hole, 11 goal
- ball_loc_X  out  10  integer ball column
- ball_loc_Y  out  10  integer ball row
- hit_a_hole  out  1  sticky fell-in-hole flag
- won_the_game  out  1  sticky goal-reached flag
- busy  out  1  update in progress

Behaviour:
- Reset values:
  - position = START_X/START_Y with fraction 0
  - vx = vy = 0
  - ball_loc_X = START_X, ball_loc_Y = START_Y
  - hit_a_hole, won_the_game, map_req, busy = 0
  - state IDLE
- Reset mid-lookup: map_req low the next cycle; any late map_ack is ignored.
- Internal state:
  - pos_x, pos_y: 14-bit unsigned (10.4)
  - vx, vy: 8-bit signed, in 1/16 px
- States: IDLE, ACCEL, PROBE_X, PROBE_Y, PROBE_F, COMMIT, HOLE, WON.
- IDLE: frame_tick -> ACCEL, busy=1. A frame_tick while busy, HOLE or WON is dropped.
- ACCEL (1 cycle):
  - v += (accel >>> ACCEL_SHIFT), computed 9-bit signed.
  - Saturate to [-VMAX, +VMAX].
- PROBE_X:
  - Candidate cx = pos_x + sign-extended vx, computed 15-bit signed.
  - If cx < 0 clamp to 0; if cx > X_MAX.15 clamp to X_MAX.0. A clamp sets vx=0.
  - Request map at (cx[13:4], pos_y[13:4]).
  - On map_ack: code 01 -> keep pos_x, vx=0. Otherwise pos_x=cx.
- PROBE_Y: same rules on the Y axis, using the updated pos_x.
- PROBE_F:
  - Lookup at the final (pos_x[13:4], pos_y[13:4]).
  - Code 10 -> pending hole; 11 -> pending goal.
- COMMIT (1 cycle):
  - ball_loc_X/Y both update in this same cycle; never mid-update.
  - If hole pending -> HOLE with hit_a_hole=1; if goal pending -> WON with won_the_game=1; else IDLE.
  - busy=0 the cycle after COMMIT.
- Map handshake:
  - map_req rises on state entry and stays high with map_x/map_y stable until the map_ack cycle.
  - map_req drops the cycle after map_ack.
  - map_ack while map_req=0 is ignored.
  - There is no timeout.
- HOLE/WON: position frozen and flag held until game_restart.
- game_restart, any state:
  - Next cycle: position = start, v=0, flags=0, map_req=0, state IDLE.
  - Has priority over a simultaneous frame_tick.

Optional Feature:
- Macro: BALL_BOUNCE_EN.
- Defined: a wall hit or boundary clamp sets that axis velocity to -(v >>> 1), arithmetic shift, so the ball rebounds at half speed.
- Undefined: that axis velocity is set to 0.
- Position behaviour is identical in both builds.

Test Plan:
- Reset, accel_x=+16, accel_y=0, map always 00, 4 frame_ticks -> vx=16, pos_x=552 (34.5 px), ball_loc_X=34, ball_loc_Y=32, busy low after each COMMIT.
- accel_x=+127, 3 ticks -> vx=31 then saturates at 48 and stays 48; accel_x=-128 drives vx down to -48 minimum.
- Ball at x=639.0, vx=+20, tick -> ball_loc_X stays 639, vx=0; with BALL_BOUNCE_EN vx=-10.
- Map returns 01 for the PROBE_X address, vx=32 -> ball_loc_X unchanged, vx=0 (bounce build: -16); Y axis still moves.
- PROBE_F returns 10 -> hit_a_hole=1 after COMMIT, subsequent ticks ignored; game_restart -> ball_loc=(32,32), hit_a_hole=0 next cycle. Repeat with 11 -> won_the_game=1.
- Delay map_ack 7 cycles with sys_rst asserted at cycle 3 -> map_req=0 next cycle, outputs at reset values, late ack ignored.
